// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM state encoding (REQ, WAIT, HOLD, DISCARD)
//   hold_entry_t  : {inst, pc4} payload parked while IF/ID is stalled
//   RESET_PC_DEFAULT, NOP_INST : reset address and the all-zero NOP word
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } hold_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: 64-bit enable register parking one fetched {inst, pc4}
// while the IF/ID register is held by a load-use stall.
//   Clk  : clock
//   Clrn : asynchronous active-low clear (buffer returns to NOP / 0)
//   en   : load d on the rising edge
//   d    : {inst, pc4} to capture
//   q    : buffered {inst, pc4}
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        en,
    input  hold_entry_t d,
    output hold_entry_t q
);

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            q.inst <= NOP_INST;
            q.pc4  <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, keeps at most one request to a variable-latency instruction
// memory in flight, and drives IF/ID data, write enable and clear.
//   Clk, Clrn            : clock, asynchronous active-low reset
//   stall                : load-use hold request from the hazard unit
//   br_taken, br_target  : resolved redirect and its address
//   imem_req, imem_addr  : request strobe / address (always the PC)
//   imem_valid, imem_rdata : response strobe / instruction word
//   if_inst, if_pc4      : IF/ID D inputs (meaningful when if_e=1)
//   if_e, if_condep      : IF/ID write enable and clear (clear dominates)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        if_e,
    output logic        if_condep
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  pc4;
    logic         hold_load;
    hold_entry_t  hold_d, hold_q;
    logic         deliver;

    // Modulo-2^32 increment: FFFF_FFFC wraps to 0.
    assign pc4 = 32'(pc + PC_STEP);

    // State and PC registers.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next state, next PC and hold-buffer load.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        hold_load = 1'b0;
        case (state)
            REQ: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    state_nxt = DISCARD;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!imem_valid) begin
                    if (br_taken) begin
                        pc_nxt    = br_target;
                        state_nxt = DISCARD;
                    end
                end else if (br_taken) begin
                    pc_nxt    = br_target;
                    state_nxt = REQ;
                end else if (stall) begin
                    hold_load = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    pc_nxt    = pc4;
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    state_nxt = REQ;
                end else if (!stall) begin
                    pc_nxt    = pc4;
                    state_nxt = REQ;
                end
            end
            DISCARD: begin
                // The stale response must drain before the target is requested.
                if (br_taken) begin
                    pc_nxt = br_target;
                end
                if (imem_valid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase
    end

    assign hold_d.inst = imem_rdata;
    assign hold_d.pc4  = pc4;

    fetch_hold_buf u_hold_buf (
        .Clk  (Clk),
        .Clrn (Clrn),
        .en   (hold_load),
        .d    (hold_d),
        .q    (hold_q)
    );

    assign deliver   = ((state == WAIT) && imem_valid) || (state == HOLD);
    assign imem_addr = pc;

    // IF/ID control and data; forced to reset values while Clrn is low.
    always_comb begin
        imem_req  = 1'b0;
        if_e      = 1'b0;
        if_condep = 1'b1;
        if_inst   = NOP_INST;
        if_pc4    = '0;
        if (Clrn) begin
            imem_req = (state == REQ);
            if (br_taken) begin
                if_e      = 1'b0;
                if_condep = 1'b1;
            end else if (stall) begin
                if_e      = 1'b0;
                if_condep = 1'b0;
            end else if (deliver) begin
                if_e      = 1'b1;
                if_condep = 1'b0;
            end
            if (state == HOLD) begin
                if_inst = hold_q.inst;
                if_pc4  = hold_q.pc4;
            end else begin
                if_inst = imem_rdata;
                if_pc4  = pc4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven check of fetch_unit. Each table row
// is one clock cycle of inputs plus the expected combinational outputs.
module tb_fetch_unit;

    logic        Clk;
    logic        Clrn;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_e;
    logic        if_condep;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] tgt;
        logic        vl;
        logic [31:0] rd;
        logic        x_req;
        logic [31:0] x_addr;
        logic        x_e;
        logic        x_cd;
        logic        dchk;
        logic [31:0] x_inst;
        logic [31:0] x_pc4;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk        (Clk),
        .Clrn       (Clrn),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .if_inst    (if_inst),
        .if_pc4     (if_pc4),
        .if_e       (if_e),
        .if_condep  (if_condep)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t v(logic st, logic br, logic [31:0] tgt, logic vl,
                               logic [31:0] rd, logic rq, logic [31:0] ad,
                               logic e, logic cd, logic dchk,
                               logic [31:0] in, logic [31:0] p4);
        vec_t r;
        r.st = st; r.br = br; r.tgt = tgt; r.vl = vl; r.rd = rd;
        r.x_req = rq; r.x_addr = ad; r.x_e = e; r.x_cd = cd;
        r.dchk = dchk; r.x_inst = in; r.x_pc4 = p4;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic vl, input logic [31:0] rd);
        stall = st; br_taken = br; br_target = tgt; imem_valid = vl; imem_rdata = rd;
    endtask

    task automatic chk_ctl(input string tag, input logic rq, input logic [31:0] ad,
                           input logic e, input logic cd);
        chk({tag, " imem_req"},  32'(imem_req),  32'(rq));
        chk({tag, " imem_addr"}, imem_addr,      ad);
        chk({tag, " if_e"},      32'(if_e),      32'(e));
        chk({tag, " if_condep"}, 32'(if_condep), 32'(cd));
    endtask

    initial begin
        //           st br tgt            vl rd              rq addr           e  cd d  inst           pc4
        vecs[0]  = v(0, 0, 32'h0,         0, 32'h0,          1, 32'h0,         0, 1, 0, 32'h0,         32'h0);
        vecs[1]  = v(0, 0, 32'h0,         1, 32'h1111_0000,  0, 32'h0,         1, 0, 1, 32'h1111_0000, 32'h4);
        vecs[2]  = v(0, 0, 32'h0,         0, 32'h0,          1, 32'h4,         0, 1, 0, 32'h0,         32'h0);
        vecs[3]  = v(0, 0, 32'h0,         1, 32'h1111_0004,  0, 32'h4,         1, 0, 1, 32'h1111_0004, 32'h8);
        vecs[4]  = v(0, 0, 32'h0,         0, 32'h0,          1, 32'h8,         0, 1, 0, 32'h0,         32'h0);
        vecs[5]  = v(1, 0, 32'h0,         1, 32'h8C22_0004,  0, 32'h8,         0, 0, 0, 32'h0,         32'h0);
        vecs[6]  = v(1, 0, 32'h0,         0, 32'h0,          0, 32'h8,         0, 0, 1, 32'h8C22_0004, 32'hC);
        vecs[7]  = v(1, 0, 32'h0,         0, 32'h0,          0, 32'h8,         0, 0, 1, 32'h8C22_0004, 32'hC);
        vecs[8]  = v(0, 0, 32'h0,         0, 32'hDEAD_BEEF,  0, 32'h8,         1, 0, 1, 32'h8C22_0004, 32'hC);
        vecs[9]  = v(0, 1, 32'h40,        0, 32'h0,          1, 32'hC,         0, 1, 0, 32'h0,         32'h0);
        vecs[10] = v(0, 0, 32'h0,         0, 32'h0,          0, 32'h40,        0, 1, 0, 32'h0,         32'h0);
        vecs[11] = v(0, 0, 32'h0,         0, 32'h0,          0, 32'h40,        0, 1, 0, 32'h0,         32'h0);
        vecs[12] = v(0, 0, 32'h0,         1, 32'hBAD0_0000,  0, 32'h40,        0, 1, 0, 32'h0,         32'h0);
        vecs[13] = v(0, 0, 32'h0,         0, 32'h0,          1, 32'h40,        0, 1, 0, 32'h0,         32'h0);
        vecs[14] = v(0, 0, 32'h0,         1, 32'h2222_0040,  0, 32'h40,        1, 0, 1, 32'h2222_0040, 32'h44);
        vecs[15] = v(0, 0, 32'h0,         0, 32'h0,          1, 32'h44,        0, 1, 0, 32'h0,         32'h0);
        vecs[16] = v(1, 0, 32'h0,         1, 32'h3333_0044,  0, 32'h44,        0, 0, 0, 32'h0,         32'h0);
        vecs[17] = v(1, 1, 32'hFFFF_FFFC, 0, 32'h0,          0, 32'h44,        0, 1, 0, 32'h0,         32'h0);
        vecs[18] = v(0, 0, 32'h0,         0, 32'h0,          1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0,         32'h0);
        vecs[19] = v(0, 0, 32'h0,         0, 32'h0,          0, 32'hFFFF_FFFC, 0, 1, 0, 32'h0,         32'h0);
        vecs[20] = v(0, 0, 32'h0,         1, 32'h4444_FFFC,  0, 32'hFFFF_FFFC, 1, 0, 1, 32'h4444_FFFC, 32'h0);
        vecs[21] = v(0, 0, 32'h0,         0, 32'h0,          1, 32'h0,         0, 1, 0, 32'h0,         32'h0);
        vecs[22] = v(0, 1, 32'h100,       0, 32'h0,          0, 32'h0,         0, 1, 0, 32'h0,         32'h0);
        vecs[23] = v(0, 1, 32'h200,       1, 32'hBAD1_0000,  0, 32'h100,       0, 1, 0, 32'h0,         32'h0);
        vecs[24] = v(1, 0, 32'h0,         0, 32'h0,          1, 32'h200,       0, 0, 0, 32'h0,         32'h0);
        vecs[25] = v(0, 1, 32'h300,       1, 32'hBAD2_0000,  0, 32'h200,       0, 1, 0, 32'h0,         32'h0);
        vecs[26] = v(0, 0, 32'h0,         0, 32'h0,          1, 32'h300,       0, 1, 0, 32'h0,         32'h0);
        vecs[27] = v(0, 0, 32'h0,         0, 32'h0,          0, 32'h300,       0, 1, 0, 32'h0,         32'h0);

        // Reset held: outputs at reset values even with a response on the bus.
        Clrn = 1'b0;
        drive(0, 0, 32'h0, 1, 32'h5A5A_5A5A);
        @(negedge Clk);
        #1;
        chk_ctl("reset", 0, 32'h0, 0, 1);
        chk("reset if_inst", if_inst, 32'h0);
        chk("reset if_pc4",  if_pc4,  32'h0);
        @(negedge Clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        Clrn = 1'b1;

        // Table: one row per cycle, inputs applied after the falling edge.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].vl, vecs[i].rd);
            #1;
            chk_ctl($sformatf("vec%0d", i), vecs[i].x_req, vecs[i].x_addr,
                    vecs[i].x_e, vecs[i].x_cd);
            if (vecs[i].dchk) begin
                chk($sformatf("vec%0d if_inst", i), if_inst, vecs[i].x_inst);
                chk($sformatf("vec%0d if_pc4", i),  if_pc4,  vecs[i].x_pc4);
            end
            @(negedge Clk);
        end

        // Reset pulsed while in WAIT at pc=0x300.
        Clrn = 1'b0;
        drive(0, 0, 32'h0, 1, 32'h5555_5555);
        #1;
        chk_ctl("midrst", 0, 32'h0, 0, 1);
        chk("midrst if_inst", if_inst, 32'h0);
        chk("midrst if_pc4",  if_pc4,  32'h0);
        @(negedge Clk);
        // Release with a late response still on the bus: REQ must ignore it.
        Clrn = 1'b1;
        #1;
        chk_ctl("rel_req", 1, 32'h0, 0, 1);
        @(negedge Clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        #1;
        chk_ctl("rel_wait", 0, 32'h0, 0, 1);
        @(negedge Clk);
        drive(0, 0, 32'h0, 1, 32'h7777_0000);
        #1;
        chk_ctl("rel_deliver", 0, 32'h0, 1, 0);
        chk("rel_deliver if_inst", if_inst, 32'h7777_0000);
        chk("rel_deliver if_pc4",  if_pc4,  32'h4);
        @(negedge Clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        #1;
        chk_ctl("rel_next", 1, 32'h4, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined CPU. It sits directly upstream of the 32-bit IF/ID pipeline registers. It owns the PC and issues one-at-a-time requests to a variable-latency instruction memory. Each cycle it drives the IF/ID register inputs (`if_inst`, `if_pc4`) and that register's write enable (`if_e`) and synchronous clear (`if_condep`), handling load-use stalls, branch/jump redirects and memory wait bubbles.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `Clk` in 1: clock, all state updates on rising edge.
- `Clrn` in 1: asynchronous active-low reset.
- `stall` in 1: hazard unit requests IF/ID hold (load-use).
- `br_taken` in 1: branch/jump resolved taken this cycle.
- `br_target` in 32: redirect address, valid with `br_taken`.
- `imem_req` out 1: request strobe; memory accepts unconditionally in the same cycle.
- `imem_addr` out 32: request address (= PC).
- `imem_valid` in 1: response strobe, at least 1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction, valid with `imem_valid`.
- `if_inst` out 32: instruction to IF/ID register D.
- `if_pc4` out 32: PC+4 of that instruction to IF/ID register D.
- `if_e` out 1: IF/ID write enable.
- `if_condep` out 1: IF/ID clear (bubble/flush), dominates `if_e`.

## Operation
- State machine with states REQ, WAIT, HOLD and DISCARD. At most one memory request is outstanding.
- REQ: `imem_req`=1, `imem_addr`=pc.
  - `br_taken` → pc<=`br_target`, go to DISCARD.
  - Otherwise go to WAIT.
- WAIT, `imem_valid`=0:
  - `br_taken` → pc<=`br_target`, go to DISCARD.
  - Otherwise stay in WAIT.
- WAIT, `imem_valid`=1:
  - `br_taken` → drop the data, pc<=`br_target`, go to REQ.
  - Else `stall` → capture `imem_rdata` and pc+4 into the hold buffer, go to HOLD.
  - Else deliver `imem_rdata` directly, pc<=pc+4, go to REQ.
- HOLD:
  - `br_taken` → drop the buffer, pc<=`br_target`, go to REQ.
  - Else `stall` → stay in HOLD.
  - Else deliver the buffer, pc<=pc+4, go to REQ.
- DISCARD:
  - `br_taken` → pc<=`br_target`, stay in DISCARD.
  - On `imem_valid`, drop the data and go to REQ. If `br_taken` coincides with `imem_valid`, the pc update still applies and the FSM still goes to REQ.
- IF/ID control is combinational from state and inputs. Priority is `br_taken` > `stall` > deliver > bubble:
  - `br_taken`: `if_condep`=1, `if_e`=0 (flush).
  - `stall`: `if_condep`=0, `if_e`=0 (hold).
  - Deliver (WAIT with `imem_valid`, or HOLD): `if_e`=1, `if_condep`=0.
  - Otherwise: `if_condep`=1, `if_e`=0 (bubble).
- `if_inst` / `if_pc4`:
  - In HOLD, driven from the hold buffer.
  - Otherwise, `imem_rdata` / pc+4.
  - They are only meaningful when `if_e`=1.
- PC arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of `br_target` are taken as given and not checked.

## Timing
- Reset (Clrn=0):
  - state=REQ, pc=`RESET_PC`, hold buffer=0.
  - `imem_req` is gated to 0.
  - `if_e`=0, `if_condep`=1, `if_inst`=0, `if_pc4`=0.
- First request goes out in the first cycle after Clrn rises.
- Minimum fetch latency is 2 cycles (REQ, then WAIT with `imem_valid`). Peak throughput is 1 instruction per 2 cycles.
- Redirect takes effect at the next edge. The first target request issues in the cycle after the stale response has been drained.
- Reset asserted mid-operation:
  - Immediately abandons any outstanding request.
  - A late `imem_valid` after reset release while in REQ is ignored. Memory must itself be reset with `Clrn`.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (REQ, WAIT, HOLD, DISCARD, 2-bit encoding);
  - the `RESET_PC` default;
  - the NOP encoding 32'h0000_0000.
- One sub-module, `fetch_hold_buf`: a 64-bit enable register holding {inst, pc4} with asynchronous active-low clear on `Clrn`.

## Test plan
- Reset release, memory latency 1, no stall: `imem_addr` = 0,4,8 on successive REQ cycles; `if_e` pulses every 2nd cycle; `if_pc4` = 4,8,12.
- `stall` held 3 cycles while `imem_valid`=1 with 32'h8C22_0004 at pc=8:
  - FSM goes to HOLD, `if_e`=0 and `if_condep`=0 for 3 cycles.
  - On release, `if_inst`=32'h8C22_0004 and `if_pc4`=12 are delivered once with `if_e`=1.
- `br_taken` with `br_target`=32'h40 in REQ, response arriving 3 cycles later:
  - `if_condep`=1 in the branch cycle, then bubbles.
  - Stale data is never delivered; the next request is at 32'h40.
- `br_taken` and `stall` together in HOLD: flush wins, `if_condep`=1, buffer dropped, next `imem_addr`=`br_target`.
- pc=32'hFFFF_FFFC delivered: the next request address is 32'h0000_0000.
- Clrn pulsed low while in WAIT: outputs return to reset values immediately, and the next request is at `RESET_PC`.
